ahb_rr_arbiter_n: RTL and testbench

//  Parametrised AHB bus arbiter for N masters; round-robin among eligible requesters.

---
 rtl/ahb_arb_pkg.sv | 47 ++++
 rtl/ahb_rr_picker.sv | 28 ++
 rtl/ahb_rr_arbiter_n.sv | 114 +++++++++++
 tb/tb_ahb_rr_arbiter_n.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and arbiter state for the round-robin bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'd0,
        HR_ERROR = 2'd1,
        HR_RETRY = 2'd2,
        HR_SPLIT = 2'd3
    } hresp_e;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        BURST = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    localparam int BEAT_W = 4;

    // Undefined-length bursts (SINGLE/INCR) report 1 so they never freeze the grant.
    function automatic logic [4:0] burst_beats(hburst_e b);
        case (b)
            HB_WRAP4,  HB_INCR4:  burst_beats = 5'd4;
            HB_WRAP8,  HB_INCR8:  burst_beats = 5'd8;
            HB_WRAP16, HB_INCR16: burst_beats = 5'd16;
            default:              burst_beats = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority encoder: first eligible index strictly after last_i, wrapping.
module ahb_rr_picker #(
    parameter int N = 3,
    parameter int W = 4
) (
    input  logic [N-1:0] elig_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found_o && elig_i[i] && (i == (int'(last_i) + k) % N)) begin
                    found_o     = 1'b1;
                    onehot_o[i] = 1'b1;
                    idx_o       = W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter_n.sv
// N-master AHB arbiter: round-robin grant, fixed-burst freeze, locked transfers, SPLIT masking.
module ahb_rr_arbiter_n
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int HMASTER_W   = 4,
    parameter int DEF_MASTER  = 0
) (
    input  logic                   HCLK_i,
    input  logic                   HRESET_i,
    input  logic [NUM_MASTERS-1:0] HBUSREQ_i,
    input  logic [NUM_MASTERS-1:0] HLOCK_i,
    input  logic [1:0]             HTRANS_i,
    input  logic [2:0]             HBURST_i,
    input  logic                   HREADY_i,
    input  logic [1:0]             HRESP_i,
    input  logic [NUM_MASTERS-1:0] HSPLIT_i,
    output logic [NUM_MASTERS-1:0] HGRANT_o,
    output logic [HMASTER_W-1:0]   HMASTER_o,
    output logic                   HMASTLOCK_o
);

    localparam logic [NUM_MASTERS-1:0] DEF_OH  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
    localparam logic [HMASTER_W-1:0]   DEF_IDX = HMASTER_W'(DEF_MASTER);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q, split_q, split_d, split_set;
    logic [HMASTER_W-1:0]   gidx_q, last_q, hmaster_q;
    logic                   hmastlock_q;
    logic [BEAT_W-1:0]      beat_q;

    logic [NUM_MASTERS-1:0] elig, pick_oh, nxt_oh;
    logic [HMASTER_W-1:0]   pick_idx, nxt_idx;
    logic                   pick_found, fixed_burst, resp_first, lock_cur, lock_nxt;

    assign elig = HBUSREQ_i & ~split_q;

    ahb_rr_picker #(.N(NUM_MASTERS), .W(HMASTER_W)) u_picker (
        .elig_i   (elig),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Nobody eligible: park on the default master even if it is split-masked.
    assign nxt_oh      = pick_found ? pick_oh  : DEF_OH;
    assign nxt_idx     = pick_found ? pick_idx : DEF_IDX;
    assign fixed_burst = (burst_beats(hburst_e'(HBURST_i)) != 5'd1);
    assign resp_first  = !HREADY_i && (HRESP_i != HR_OKAY);
    assign lock_cur    = |(HLOCK_i & grant_q);
    assign lock_nxt    = |(HLOCK_i & nxt_oh);

    // A resume pulse beats a SPLIT landing on the same master in the same cycle.
    always_comb begin
        split_set = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            split_set[i] = resp_first && (HRESP_i == HR_SPLIT) &&
                           (hmaster_q != DEF_IDX) && (hmaster_q == HMASTER_W'(i));
        end
        split_d = (split_q | split_set) & ~HSPLIT_i;
    end

    always_ff @(posedge HCLK_i) begin
        if (HRESET_i) begin
            state_q     <= ARB;
            grant_q     <= DEF_OH;
            gidx_q      <= DEF_IDX;
            last_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            split_q     <= '0;
            beat_q      <= '0;
        end else begin
            split_q <= split_d;
            if (resp_first) begin
                state_q <= ARB;
                beat_q  <= '0;
            end else if (HREADY_i) begin
                hmaster_q   <= gidx_q;
                hmastlock_q <= lock_cur;
                case (state_q)
                    ARB: begin
                        if (HTRANS_i == HT_NONSEQ && fixed_burst) begin
                            beat_q  <= BEAT_W'(burst_beats(hburst_e'(HBURST_i)) - 5'd1);
                            state_q <= BURST;
                        end else begin
                            grant_q <= nxt_oh;
                            gidx_q  <= nxt_idx;
                            last_q  <= nxt_idx;
                            if (lock_nxt) state_q <= LOCK;
                        end
                    end
                    // Leave one beat early so the next grant lines up with the final address.
                    BURST: begin
                        if (HTRANS_i == HT_SEQ) begin
                            beat_q <= beat_q - 1'b1;
                            if (beat_q <= BEAT_W'(2)) state_q <= ARB;
                        end
                    end
                    LOCK: begin
                        if (!lock_cur) state_q <= ARB;
                    end
                    default: state_q <= ARB;
                endcase
            end
        end
    end

    assign HGRANT_o    = grant_q;
    assign HMASTER_o   = hmaster_q;
    assign HMASTLOCK_o = hmastlock_q;

endmodule

// File: tb/tb_ahb_rr_arbiter_n.sv
// Directed bench for ahb_rr_arbiter_n (N=3, default master 0) with an expected-value queue.
module tb_ahb_rr_arbiter_n;
    import ahb_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] breq, lock, hsplit;
    logic [1:0] trans, resp;
    logic [2:0] burst;
    logic       rdy;
    logic [2:0] grant;
    logic [3:0] hmaster;
    logic       mlock;

    typedef struct {
        logic [2:0] g;
        logic [3:0] m;
        logic       l;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ahb_rr_arbiter_n #(.NUM_MASTERS(3), .HMASTER_W(4), .DEF_MASTER(0)) dut (
        .HCLK_i      (clk),
        .HRESET_i    (rst),
        .HBUSREQ_i   (breq),
        .HLOCK_i     (lock),
        .HTRANS_i    (trans),
        .HBURST_i    (burst),
        .HREADY_i    (rdy),
        .HRESP_i     (resp),
        .HSPLIT_i    (hsplit),
        .HGRANT_o    (grant),
        .HMASTER_o   (hmaster),
        .HMASTLOCK_o (mlock)
    );

    // Push the expectation for the inputs currently driven, advance one edge, pop and compare.
    task automatic cyc(input logic [2:0] eg, input logic [3:0] em, input logic el, input string tag);
        exp_t e;
        sb.push_back('{g: eg, m: em, l: el, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (grant === e.g) else begin
            errors++;
            $error("FAIL %s HGRANT got %b want %b", e.tag, grant, e.g);
        end
        checks++;
        assert (hmaster === e.m) else begin
            errors++;
            $error("FAIL %s HMASTER got %0d want %0d", e.tag, hmaster, e.m);
        end
        checks++;
        assert (mlock === e.l) else begin
            errors++;
            $error("FAIL %s HMASTLOCK got %b want %b", e.tag, mlock, e.l);
        end
    endtask

    initial begin
        rst = 1'b1; breq = 3'b000; lock = 3'b000; hsplit = 3'b000;
        trans = HT_IDLE; burst = HB_SINGLE; rdy = 1'b1; resp = HR_OKAY;

        // Reset state
        cyc(3'b001, 4'd0, 1'b0, "reset0");
        breq = 3'b111;
        cyc(3'b001, 4'd0, 1'b0, "reset1");
        rst = 1'b0;

        // Round-robin fairness from last=0
        cyc(3'b010, 4'd0, 1'b0, "rr1");
        cyc(3'b100, 4'd1, 1'b0, "rr2");
        cyc(3'b001, 4'd2, 1'b0, "rr3");
        cyc(3'b010, 4'd0, 1'b0, "rr4");

        // Fixed burst: M1 alone, then INCR8 with M2 requesting; two BUSY beats
        breq = 3'b010;
        cyc(3'b010, 4'd1, 1'b0, "m1_own");
        breq = 3'b110; trans = HT_NONSEQ; burst = HB_INCR8;
        cyc(3'b010, 4'd1, 1'b0, "b_nseq");
        trans = HT_SEQ;  cyc(3'b010, 4'd1, 1'b0, "b_seq1");
        trans = HT_SEQ;  cyc(3'b010, 4'd1, 1'b0, "b_seq2");
        trans = HT_BUSY; cyc(3'b010, 4'd1, 1'b0, "b_busy1");
        trans = HT_SEQ;  rdy = 1'b0;
        cyc(3'b010, 4'd1, 1'b0, "b_wait");
        rdy = 1'b1;      cyc(3'b010, 4'd1, 1'b0, "b_seq3");
        trans = HT_SEQ;  cyc(3'b010, 4'd1, 1'b0, "b_seq4");
        trans = HT_BUSY; cyc(3'b010, 4'd1, 1'b0, "b_busy2");
        trans = HT_SEQ;  cyc(3'b010, 4'd1, 1'b0, "b_seq5");
        trans = HT_SEQ;  cyc(3'b010, 4'd1, 1'b0, "b_seq6");
        trans = HT_SEQ;  cyc(3'b100, 4'd1, 1'b0, "b_seq7_switch");

        // Locked transfers by M2
        trans = HT_IDLE; burst = HB_SINGLE; breq = 3'b111;
        cyc(3'b001, 4'd2, 1'b0, "pre_l1");
        cyc(3'b010, 4'd0, 1'b0, "pre_l2");
        lock = 3'b100;
        cyc(3'b100, 4'd1, 1'b0, "lock_grant");
        for (int i = 0; i < 5; i++) begin
            cyc(3'b100, 4'd2, 1'b1, $sformatf("lock_xfer%0d", i));
            if (i == 2) begin
                rdy = 1'b0;
                cyc(3'b100, 4'd2, 1'b1, "lock_wait");
                rdy = 1'b1;
            end
        end
        lock = 3'b000;
        cyc(3'b100, 4'd2, 1'b0, "lock_release");
        cyc(3'b001, 4'd2, 1'b0, "after_lock");

        // SPLIT on M1, M1 skipped until HSPLIT resumes it
        cyc(3'b010, 4'd0, 1'b0, "sp_g1");
        cyc(3'b100, 4'd1, 1'b0, "sp_g2");
        rdy = 1'b0; resp = HR_SPLIT;
        cyc(3'b100, 4'd1, 1'b0, "sp_resp1");
        rdy = 1'b1;
        cyc(3'b001, 4'd2, 1'b0, "sp_resp2");
        resp = HR_OKAY;
        cyc(3'b100, 4'd0, 1'b0, "sp_skip1");
        cyc(3'b001, 4'd2, 1'b0, "sp_skip2");
        cyc(3'b100, 4'd0, 1'b0, "sp_skip3");
        hsplit = 3'b010;
        cyc(3'b001, 4'd2, 1'b0, "sp_resume");
        hsplit = 3'b000;
        cyc(3'b010, 4'd0, 1'b0, "sp_m1_back");

        // Split M1 and M2; only they request -> default master
        cyc(3'b100, 4'd1, 1'b0, "am_g2");
        rdy = 1'b0; resp = HR_SPLIT;
        cyc(3'b100, 4'd1, 1'b0, "am_sp1a");
        rdy = 1'b1;
        cyc(3'b001, 4'd2, 1'b0, "am_sp1b");
        rdy = 1'b0;
        cyc(3'b001, 4'd2, 1'b0, "am_sp2a");
        rdy = 1'b1;
        cyc(3'b001, 4'd0, 1'b0, "am_sp2b");
        resp = HR_OKAY; breq = 3'b110;
        cyc(3'b001, 4'd0, 1'b0, "all_masked1");
        cyc(3'b001, 4'd0, 1'b0, "all_masked2");

        // Resume M1 only, run INCR16, reset mid-burst; M2's mask must be gone afterwards
        hsplit = 3'b010;
        cyc(3'b001, 4'd0, 1'b0, "rb_resume");
        hsplit = 3'b000; breq = 3'b010;
        cyc(3'b010, 4'd0, 1'b0, "rb_g1");
        cyc(3'b010, 4'd1, 1'b0, "rb_own");
        breq = 3'b110; trans = HT_NONSEQ; burst = HB_INCR16;
        cyc(3'b010, 4'd1, 1'b0, "rb_nseq");
        trans = HT_SEQ;
        cyc(3'b010, 4'd1, 1'b0, "rb_seq1");
        cyc(3'b010, 4'd1, 1'b0, "rb_seq2");
        rst = 1'b1;
        cyc(3'b001, 4'd0, 1'b0, "rb_reset");
        rst = 1'b0; breq = 3'b100; trans = HT_IDLE; burst = HB_SINGLE;
        cyc(3'b100, 4'd0, 1'b0, "rb_mask_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
